// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the core until the load is done.
// Each word is written one cycle after its 4th byte; in_ready is low in RUN/ERR and during the final write.
module program_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, RUN, ERR} state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state, state_nxt;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_hdr;
  logic [1:0]  lane;
  logic [23:0] word_buf;
  logic        last_wr;
  logic        hs;
  logic        final_word;

  assign hs         = in_valid & in_ready;
  assign len_hdr    = {in_data, len_lo};
  assign final_word = (words_loaded == len - 16'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= LEN_LO;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    core_hold = 1'b1;
    error     = 1'b0;
    case (state)
      LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (len_hdr == 16'd0)                 state_nxt = RUN;
          else if ({1'b0, len_hdr} > DEPTH_W)   state_nxt = ERR;
          else                                  state_nxt = DATA;
        end
      end
      DATA: begin
        // Once the last word's fourth byte is in, stop taking bytes and leave after its write.
        in_ready = ~last_wr;
        if (last_wr) state_nxt = RUN;
      end
      RUN: begin
        core_hold = 1'b0;
        if (reload) state_nxt = LEN_LO;
      end
      ERR: begin
        error = 1'b1;
        if (reload) state_nxt = LEN_LO;
      end
      default: state_nxt = LEN_LO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_lo       <= '0;
      len          <= '0;
      lane         <= '0;
      word_buf     <= '0;
      last_wr      <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      last_wr <= 1'b0;
      if (hs && state == LEN_LO) len_lo <= in_data;
      if (hs && state == LEN_HI) begin
        len          <= len_hdr;
        lane         <= '0;
        words_loaded <= '0;
      end
      if (hs && state == DATA) begin
        lane <= lane + 2'd1;
        if (lane == 2'd3) begin
          imem_we      <= 1'b1;
          imem_addr    <= words_loaded[ADDR_W-1:0];
          imem_wdata   <= {in_data, word_buf};
          words_loaded <= words_loaded + 16'd1;
          last_wr      <= final_word;
        end else begin
          word_buf[{lane, 3'b000} +: 8] <= in_data;
        end
      end
      if ((state == RUN || state == ERR) && reload) words_loaded <= '0;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: header/data loads, empty and oversize headers, reload and reset.
module tb_program_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clock    = 1'b0;
  logic              reset_n  = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data  = 8'h00;
  logic              reload   = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              error;
  logic [15:0]       words_loaded;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int hold_fall   = -1;
  logic prev_hold = 1'b1;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  int                wc_q[$];

  program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_hold(core_hold), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      wc_q.push_back(cyc);
    end
    if (prev_hold === 1'b1 && core_hold === 1'b0) hold_fall = cyc;
    prev_hold = core_hold;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick(gap);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 64) begin
      tick(1);
      n++;
    end
    if (n >= 64) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick(1);
    reload = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_addr"}, (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hxxxxxxxx, addr);
    chk({tag, "_data"}, (i < wd_q.size()) ? wd_q[i] : 32'hxxxxxxxx, data);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    hold_fall = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    #3 reset_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Two-word streamed load
    clear_log();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'h00500013, 0);
    send_word(32'h00A00093, 0);
    chk("t1_last_we", 32'(imem_we), 32'd1);
    chk("t1_last_rdy", 32'(in_ready), 32'd0);
    chk("t1_last_hold", 32'(core_hold), 32'd1);
    tick(2);
    chk("t1_wr_cnt", 32'(wa_q.size()), 32'd2);
    chk_wr("t1_w0", 0, 32'd0, 32'h00500013);
    chk_wr("t1_w1", 1, 32'd1, 32'h00A00093);
    chk("t1_hold_fall", 32'(hold_fall), (wc_q.size() == 2) ? 32'(wc_q[1] + 1) : 32'hxxxxxxxx);
    chk("t1_words", 32'(words_loaded), 32'd2);
    chk("t1_run_rdy", 32'(in_ready), 32'd0);

    // Empty program
    pulse_reload();
    chk("t2_reload_hold", 32'(core_hold), 32'd1);
    chk("t2_reload_words", 32'(words_loaded), 32'd0);
    chk("t2_reload_rdy", 32'(in_ready), 32'd1);
    clear_log();
    send_byte(8'h00, 0);
    chk("t2_hdr1_hold", 32'(core_hold), 32'd1);
    send_byte(8'h00, 0);
    chk("t2_hdr2_hold", 32'(core_hold), 32'd0);
    tick(3);
    chk("t2_wr_cnt", 32'(wa_q.size()), 32'd0);

    // Oversize header 257
    pulse_reload();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_rdy", 32'(in_ready), 32'd0);
    chk("t3_hold", 32'(core_hold), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick(4);
    in_valid = 1'b0;
    chk("t3_err_wr_cnt", 32'(wa_q.size()), 32'd0);
    chk("t3_err_stays", 32'(error), 32'd1);
    pulse_reload();
    chk("t3_reload_err", 32'(error), 32'd0);
    chk("t3_reload_rdy", 32'(in_ready), 32'd1);
    chk("t3_reload_hold", 32'(core_hold), 32'd1);

    // Three words with random in_valid gaps
    clear_log();
    send_byte(8'h03, 2);
    send_byte(8'h00, 1);
    send_word(32'hDEADBEEF, 3);
    send_word(32'h01234567, 3);
    send_word(32'h89ABCDEF, 3);
    tick(2);
    chk("t4_wr_cnt", 32'(wa_q.size()), 32'd3);
    chk_wr("t4_w0", 0, 32'd0, 32'hDEADBEEF);
    chk_wr("t4_w1", 1, 32'd1, 32'h01234567);
    chk_wr("t4_w2", 2, 32'd2, 32'h89ABCDEF);
    chk("t4_hold", 32'(core_hold), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick(5);
    chk("t4_run_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    chk("t4_run_wr_cnt", 32'(wa_q.size()), 32'd3);
    chk("t4_run_words", 32'(words_loaded), 32'd3);
    chk("t4_run_hold", 32'(core_hold), 32'd0);

    // Header of exactly DEPTH, then reset mid-word
    pulse_reload();
    clear_log();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    chk("t5_depth_err", 32'(error), 32'd0);
    chk("t5_depth_rdy", 32'(in_ready), 32'd1);
    send_word(32'hCAFEF00D, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_rdy", 32'(in_ready), 32'd1);
    chk("t5_rst_we", 32'(imem_we), 32'd0);
    chk("t5_rst_addr", 32'(imem_addr), 32'd0);
    chk("t5_rst_wdata", imem_wdata, 32'd0);
    chk("t5_rst_hold", 32'(core_hold), 32'd1);
    chk("t5_rst_error", 32'(error), 32'd0);
    chk("t5_rst_words", 32'(words_loaded), 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick(3);
    chk("t5_no_partial", 32'(wa_q.size()), 32'd1);
    chk_wr("t5_w0", 0, 32'd0, 32'hCAFEF00D);
    clear_log();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'h11223344, 0);
    tick(2);
    chk("t5_reload_wr_cnt", 32'(wa_q.size()), 32'd1);
    chk_wr("t5_reload_w0", 0, 32'd0, 32'h11223344);
    chk("t5_reload_hold", 32'(core_hold), 32'd0);
    chk("t5_reload_words", 32'(words_loaded), 32'd1);

    // Reload during DATA is ignored
    pulse_reload();
    clear_log();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    pulse_reload();
    chk("t6_data_rdy", 32'(in_ready), 32'd1);
    chk("t6_data_hold", 32'(core_hold), 32'd1);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_word(32'h76543210, 0);
    tick(2);
    chk("t6_wr_cnt", 32'(wa_q.size()), 32'd2);
    chk_wr("t6_w0", 0, 32'd0, 32'h04030201);
    chk_wr("t6_w1", 1, 32'd1, 32'h76543210);
    chk("t6_hold", 32'(core_hold), 32'd0);
    chk("t6_words", 32'(words_loaded), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
